// File: rtl/apb_req_arbiter.sv
// Two-requester APB master arbiter with round-robin grant and an optional
// ACCESS-phase timeout enabled by defining APB_ARB_TIMEOUT_EN.
module apb_req_arbiter #(
    parameter int ADDR_W  = 32,
    parameter int DATA_W  = 32,
    parameter int TIMEOUT = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [1:0]        req_i,
    input  logic [1:0]        write_i,
    input  logic [ADDR_W-1:0] addr0_i,
    input  logic [ADDR_W-1:0] addr1_i,
    input  logic [DATA_W-1:0] wdata0_i,
    input  logic [DATA_W-1:0] wdata1_i,
    output logic [1:0]        done_o,
    output logic              err_o,
    output logic [DATA_W-1:0] rdata_o,
    output logic              psel_o,
    output logic              penable_o,
    output logic              pwrite_o,
    output logic [ADDR_W-1:0] paddr_o,
    output logic [DATA_W-1:0] pwdata_o,
    input  logic              pready_i,
    input  logic [DATA_W-1:0] prdata_i
);

    typedef enum logic [1:0] {
        IDLE,
        SETUP,
        ACCESS,
        DONE
    } state_t;

    state_t            state_q;
    state_t            state_d;
    logic              last_q;
    logic              gnt_q;
    logic              sel;
    logic              wr_q;
    logic [ADDR_W-1:0] addr_q;
    logic [DATA_W-1:0] wdata_q;
    logic [DATA_W-1:0] rdata_q;
    logic              start;
    logic              finish;
    logic              expire;

    // On contention the requester not served last wins.
    always_comb begin
        sel = 1'b0;
        unique case (req_i)
            2'b01:   sel = 1'b0;
            2'b10:   sel = 1'b1;
            2'b11:   sel = ~last_q;
            default: sel = 1'b0;
        endcase
    end

    assign start  = (state_q == IDLE) && (req_i != 2'b00);
    assign finish = (state_q == ACCESS) && pready_i;

`ifdef APB_ARB_TIMEOUT_EN
    localparam int CW = $clog2(TIMEOUT + 1);

    logic [CW-1:0] cnt_q;
    logic          err_q;

    // The limit fires on the TIMEOUT-th stalled ACCESS cycle; pready wins.
    assign expire = (state_q == ACCESS) && !pready_i
                    && (cnt_q == CW'(TIMEOUT - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
            err_q <= 1'b0;
        end else begin
            if (state_q == SETUP) begin
                cnt_q <= '0;
            end else if (state_q == ACCESS && !pready_i) begin
                cnt_q <= cnt_q + 1'b1;
            end
            if (finish) begin
                err_q <= 1'b0;
            end else if (expire) begin
                err_q <= 1'b1;
            end
        end
    end

    assign err_o = err_q && (state_q == DONE);
`else
    assign expire = 1'b0;
    assign err_o  = 1'b0;
`endif

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE: begin
                if (req_i != 2'b00) begin
                    state_d = SETUP;
                end
            end
            SETUP: begin
                state_d = ACCESS;
            end
            ACCESS: begin
                if (finish || expire) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Operands are captured only at grant so requester activity
    // during a transfer cannot disturb the bus.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            last_q  <= 1'b1;
            gnt_q   <= 1'b0;
            wr_q    <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
        end else if (start) begin
            last_q  <= sel;
            gnt_q   <= sel;
            wr_q    <= sel ? write_i[1] : write_i[0];
            addr_q  <= sel ? addr1_i : addr0_i;
            wdata_q <= sel ? wdata1_i : wdata0_i;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rdata_q <= '0;
        end else if (finish) begin
            if (!wr_q) begin
                rdata_q <= prdata_i;
            end
        end else if (expire) begin
            rdata_q <= '0;
        end
    end

    assign psel_o    = (state_q == SETUP) || (state_q == ACCESS);
    assign penable_o = (state_q == ACCESS);
    assign pwrite_o  = wr_q;
    assign paddr_o   = addr_q;
    assign pwdata_o  = wdata_q;
    assign rdata_o   = rdata_q;
    assign done_o    = (state_q != DONE) ? 2'b00
                     : (gnt_q ? 2'b10 : 2'b01);

endmodule

// File: tb/tb_apb_req_arbiter.sv
// Randomized bench for apb_req_arbiter against a transaction-level model,
// plus directed scenarios with literal expectations.
module tb_apb_req_arbiter;

    localparam int AW  = 32;
    localparam int DW  = 32;
    localparam int TMO = 16;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic [1:0]    req_i = '0;
    logic [1:0]    write_i = '0;
    logic [AW-1:0] addr0_i = '0;
    logic [AW-1:0] addr1_i = '0;
    logic [DW-1:0] wdata0_i = '0;
    logic [DW-1:0] wdata1_i = '0;
    logic [1:0]    done_o;
    logic          err_o;
    logic [DW-1:0] rdata_o;
    logic          psel_o;
    logic          penable_o;
    logic          pwrite_o;
    logic [AW-1:0] paddr_o;
    logic [DW-1:0] pwdata_o;
    logic          pready_i = 1'b0;
    logic [DW-1:0] prdata_i = '0;

    int tests = 0;
    int fails = 0;

    apb_req_arbiter #(
        .ADDR_W (AW),
        .DATA_W (DW),
        .TIMEOUT(TMO)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .req_i    (req_i),
        .write_i  (write_i),
        .addr0_i  (addr0_i),
        .addr1_i  (addr1_i),
        .wdata0_i (wdata0_i),
        .wdata1_i (wdata1_i),
        .done_o   (done_o),
        .err_o    (err_o),
        .rdata_o  (rdata_o),
        .psel_o   (psel_o),
        .penable_o(penable_o),
        .pwrite_o (pwrite_o),
        .paddr_o  (paddr_o),
        .pwdata_o (pwdata_o),
        .pready_i (pready_i),
        .prdata_i (prdata_i)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [63:0] act,
                       input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h at %0t",
                     nm, act, exp, $time);
        end
    endtask

    // Transaction model: one transfer owned at a time, t counts cycles
    // since the grant (1 = address phase, >=2 = data phase).
    bit          m_owned;
    bit          m_fin;
    int          m_t;
    int          m_wait;
    int          m_owner;
    int          m_last;
    bit          m_wr;
    logic [AW-1:0] m_addr;
    logic [DW-1:0] m_wdata;
    logic [DW-1:0] m_rdata;
    bit          m_err;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_owned = 0;
            m_fin   = 0;
            m_t     = 0;
            m_wait  = 0;
            m_last  = 1;
            m_rdata = '0;
            m_err   = 0;
            m_wr    = 0;
            m_addr  = '0;
            m_wdata = '0;
            m_owner = 0;
        end else if (!m_owned) begin
            if (req_i != 2'b00) begin
                if (req_i == 2'b11) m_owner = 1 - m_last;
                else m_owner = req_i[1] ? 1 : 0;
                m_last  = m_owner;
                m_wr    = write_i[m_owner];
                m_addr  = m_owner ? addr1_i : addr0_i;
                m_wdata = m_owner ? wdata1_i : wdata0_i;
                m_owned = 1;
                m_fin   = 0;
                m_t     = 1;
                m_wait  = 0;
            end
        end else if (m_fin) begin
            m_owned = 0;
        end else begin
            if (m_t >= 2) begin
                if (pready_i) begin
                    m_fin = 1;
                    m_err = 0;
                    if (!m_wr) m_rdata = prdata_i;
                end else begin
                    m_wait++;
`ifdef APB_ARB_TIMEOUT_EN
                    if (m_wait == TMO) begin
                        m_fin   = 1;
                        m_err   = 1;
                        m_rdata = '0;
                    end
`endif
                end
            end
            m_t++;
        end
    end

    always @(negedge clk) begin
        if (rst_n) begin
            bit e_sel;
            bit e_en;
            logic [1:0] e_done;
            e_sel  = m_owned && !m_fin;
            e_en   = e_sel && (m_t >= 2);
            e_done = (m_owned && m_fin) ? (m_owner ? 2'b10 : 2'b01) : 2'b00;
            chk("m_psel", psel_o, e_sel);
            chk("m_penable", penable_o, e_en);
            chk("m_done", done_o, e_done);
            chk("m_err", err_o, (m_owned && m_fin) ? m_err : 1'b0);
            chk("m_rdata", rdata_o, m_rdata);
            if (e_sel) begin
                chk("m_paddr", paddr_o, m_addr);
                chk("m_pwrite", pwrite_o, m_wr);
                chk("m_pwdata", pwdata_o, m_wdata);
            end
        end
    end

    task automatic new_ops(input int i);
        write_i[i] = 1'($urandom_range(0, 1));
        if (i == 0) begin
            addr0_i  = $urandom;
            wdata0_i = $urandom;
        end else begin
            addr1_i  = $urandom;
            wdata1_i = $urandom;
        end
    endtask

    initial begin
        int n;
        int pen;
        bit got;

        repeat (2) @(negedge clk);
        chk("rst_psel", psel_o, 0);
        chk("rst_penable", penable_o, 0);
        chk("rst_done", done_o, 0);
        chk("rst_err", err_o, 0);
        chk("rst_rdata", rdata_o, 0);
        chk("rst_paddr", paddr_o, 0);
        rst_n = 1'b1;

        @(negedge clk);
        req_i    = 2'b01;
        write_i  = 2'b00;
        addr0_i  = 32'h1000;
        pready_i = 1'b1;
        prdata_i = 32'hCAFE0001;
        @(negedge clk);
        chk("rd_setup_psel", psel_o, 1);
        chk("rd_setup_pen", penable_o, 0);
        chk("rd_paddr", paddr_o, 32'h1000);
        chk("rd_pwrite", pwrite_o, 0);
        @(negedge clk);
        chk("rd_access_pen", penable_o, 1);
        @(negedge clk);
        chk("rd_done", done_o, 2'b01);
        chk("rd_rdata", rdata_o, 32'hCAFE0001);
        chk("rd_done_psel", psel_o, 0);
        req_i = 2'b00;
        @(negedge clk);
        chk("rd_idle_done", done_o, 0);

        rst_n = 1'b0;
        @(negedge clk);
        rst_n    = 1'b1;
        req_i    = 2'b11;
        addr0_i  = 32'h100;
        addr1_i  = 32'h200;
        prdata_i = 32'h12345678;
        n = 0;
        for (int c = 0; c < 20 && n < 3; c++) begin
            @(negedge clk);
            if (psel_o)
                chk("cont_paddr", paddr_o, (n % 2 == 0) ? 32'h100 : 32'h200);
            if (done_o != 2'b00) begin
                chk("cont_done", done_o, (n % 2 == 0) ? 2'b01 : 2'b10);
                n++;
            end
        end
        req_i = 2'b00;
        chk("cont_count", n, 3);

        @(negedge clk);
        req_i    = 2'b10;
        write_i  = 2'b10;
        addr1_i  = 32'h20;
        wdata1_i = 32'h55;
        pready_i = 1'b0;
        pen = 0;
        got = 0;
        for (int c = 0; c < 20 && !got; c++) begin
            @(negedge clk);
            if (psel_o) begin
                chk("ws_paddr", paddr_o, 32'h20);
                chk("ws_pwdata", pwdata_o, 32'h55);
                chk("ws_pwrite", pwrite_o, 1);
            end
            if (penable_o) begin
                pen++;
                pready_i = (pen == 4);
            end
            if (done_o != 2'b00) begin
                got = 1;
                chk("ws_done", done_o, 2'b10);
                chk("ws_rdata", rdata_o, 32'h12345678);
            end
        end
        req_i    = 2'b00;
        pready_i = 1'b0;
        chk("ws_got", got, 1);
        chk("ws_penable_cycles", pen, 4);

        @(negedge clk);
        req_i   = 2'b10;
        write_i = 2'b00;
        repeat (3) @(negedge clk);
        chk("ra_in_access", penable_o, 1);
        #1 rst_n = 1'b0;
        #1;
        chk("ra_psel", psel_o, 0);
        chk("ra_penable", penable_o, 0);
        chk("ra_done", done_o, 0);
        #1 rst_n = 1'b1;
        req_i = 2'b00;
        repeat (3) begin
            @(negedge clk);
            chk("ra_no_done", done_o, 0);
        end
        req_i    = 2'b11;
        addr0_i  = 32'h300;
        addr1_i  = 32'h400;
        pready_i = 1'b1;
        @(negedge clk);
        chk("ra_first_psel", psel_o, 1);
        chk("ra_first_paddr", paddr_o, 32'h300);
        repeat (2) @(negedge clk);
        chk("ra_first_done", done_o, 2'b01);
        req_i = 2'b00;
        pready_i = 1'b0;
        repeat (2) @(negedge clk);

`ifdef APB_ARB_TIMEOUT_EN
        for (int k = 0; k < 2; k++) begin
            req_i   = 2'b01;
            write_i = 2'b00;
            pen = 0;
            got = 0;
            for (int c = 0; c < 40 && !got; c++) begin
                @(negedge clk);
                if (penable_o) begin
                    pen++;
                    pready_i = (k == 1) && (pen == TMO);
                    prdata_i = 32'hBEEF;
                end
                if (done_o != 2'b00) begin
                    got = 1;
                    chk("to_err", err_o, (k == 0));
                    chk("to_rdata", rdata_o, (k == 0) ? 32'h0 : 32'hBEEF);
                end
            end
            req_i    = 2'b00;
            pready_i = 1'b0;
            chk("to_got", got, 1);
            chk("to_cycles", pen, TMO);
            @(negedge clk);
        end
`endif

        repeat (600) begin
            @(negedge clk);
            for (int i = 0; i < 2; i++) begin
                if (done_o[i]) begin
                    if ($urandom_range(0, 1) == 1) new_ops(i);
                    else req_i[i] = 1'b0;
                end else if (!req_i[i] && $urandom_range(0, 3) == 0) begin
                    new_ops(i);
                    req_i[i] = 1'b1;
                end
            end
            pready_i = ($urandom_range(0, 2) != 0);
            prdata_i = $urandom;
        end
        req_i = 2'b00;
        got = 0;
        for (int c = 0; c < 60 && !got; c++) begin
            @(negedge clk);
            got = !psel_o && (done_o == 2'b00);
        end
        chk("drain_idle", got, 1);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
